bin2bcd_ctrl: RTL

BIN2BCD_CTRL -- requirements
Module: bin2bcd_ctrl

---
 rtl/bin2bcd_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_ctrl.sv
// rtl/bin2bcd_ctrl.sv - controller feeding a serial shift-add-3 BCD digit chain
module bin2bcd_ctrl #(
  parameter int NBITS = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_bin,
  output logic             chain_clr,
  output logic             bin_stream,
  input  logic [3:0]       dig_uni,
  input  logic [3:0]       dig_dec,
  input  logic [3:0]       dig_cen,
  input  logic [3:0]       dig_mil,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      bcd,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);
  localparam logic [NBITS-1:0] MAX_DEC = NBITS'(9999);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [NBITS-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_err_q;
  logic             r_chain_clr;
  logic             r_bin_stream;
  logic [15:0]      r_bcd;
  logic             r_err;

  // Next-state decode; in_valid and out_ready only matter in IDLE and HOLD
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_SHIFT;
      S_SHIFT:   if (r_cnt == LAST_CNT) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Word register, overflow flag and bit counter; MSB is presented one cycle ahead of use
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_err_q <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= in_bin;
            r_err_q <= (in_bin > MAX_DEC);
          end
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_shift <= r_shift << 1;
        end
        S_SHIFT: begin
          r_cnt   <= r_cnt + 1'b1;
          r_shift <= r_shift << 1;
        end
        default: ;
      endcase
    end
  end

  // Registered chain controls, driven from the state being entered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chain_clr  <= 1'b1;
      r_bin_stream <= 1'b0;
    end else begin
      r_chain_clr  <= (w_next == S_CLEAR);
      r_bin_stream <= (w_next == S_SHIFT) ? r_shift[NBITS-1] : 1'b0;
    end
  end

  // Result capture; saturates to 9999 on overflow and holds until the next capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= 16'h0000;
      r_err <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_bcd <= r_err_q ? 16'h9999 : {dig_mil, dig_cen, dig_dec, dig_uni};
      r_err <= r_err_q;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign chain_clr  = r_chain_clr;
  assign bin_stream = r_bin_stream;
  assign bcd        = r_bcd;
  assign err        = r_err;

endmodule
